// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants and visible-area boundaries for the
// timing generator and the pixel-colour generators that consume its counters.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned COORD_MAX = 1024;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_PIX_DIV  = 4;

  localparam int unsigned VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;

  // Line/frame order is sync, back porch, active, front porch.
  localparam int unsigned VGA_H_VIS_START = VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_H_VIS_END   = VGA_H_VIS_START + VGA_H_ACTIVE;
  localparam int unsigned VGA_V_VIS_START = VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_V_VIS_END   = VGA_V_VIS_START + VGA_V_ACTIVE;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from vga_timing_gen to the pixel-colour generators and the
// board sync pins.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   hSync;
  logic   vSync;
  logic   bright;
  coord_t hCount;
  coord_t vCount;
  logic   pixelTick;
  logic   frameStart;

  modport master (
    output hSync, vSync, bright, hCount, vCount, pixelTick, frameStart
  );

  modport slave (
    input hSync, vSync, bright, hCount, vCount, pixelTick, frameStart
  );

endinterface

// File: rtl/vga_timing_gen_pixel_div.sv
// Pixel-clock-enable divider: pix_en is high on the last of every PIX_DIV clks.
module vga_pixel_div #(
  parameter int unsigned PIX_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0] div_cnt;

  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + 4'd1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical timing generator with registered sync/bright decode.
// Define VGA_PIXEL_DIV_EN to divide clk by PIX_DIV; otherwise clk is the pixel clock.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned PIX_DIV  = VGA_PIX_DIV
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (PIX_DIV < 2 || PIX_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be in 2..16");
  end

  localparam coord_t H_LAST = 10'(H_TOTAL - 1);
  localparam coord_t V_LAST = 10'(V_TOTAL - 1);

  // 11-bit boundaries so a visible-area end of exactly 1024 does not wrap.
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] H_VIS_BEG  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_VIS_END  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_VIS_BEG  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_VIS_END  = 11'(V_SYNC + V_BP + V_ACTIVE);

  logic   pix_en;
  coord_t h_next;
  coord_t v_next;

`ifdef VGA_PIXEL_DIV_EN
  vga_pixel_div #(.PIX_DIV(PIX_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en)
  );
`else
  assign pix_en = 1'b1;
`endif

  always_comb begin
    h_next = vga.hCount;
    v_next = vga.vCount;
    if (pix_en) begin
      if (vga.hCount == H_LAST) begin
        h_next = '0;
        v_next = (vga.vCount == V_LAST) ? '0 : vga.vCount + 10'd1;
      end else begin
        h_next = vga.hCount + 10'd1;
      end
    end
  end

  // Decoding from the next counter values keeps every output on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga.hCount     <= '0;
      vga.vCount     <= '0;
      vga.hSync      <= 1'b0;
      vga.vSync      <= 1'b0;
      vga.bright     <= 1'b0;
      vga.pixelTick  <= 1'b0;
      vga.frameStart <= 1'b0;
    end else begin
      vga.hCount     <= h_next;
      vga.vCount     <= v_next;
      vga.hSync      <= ({1'b0, h_next} >= H_SYNC_END);
      vga.vSync      <= ({1'b0, v_next} >= V_SYNC_END);
      vga.bright     <= ({1'b0, h_next} >= H_VIS_BEG) && ({1'b0, h_next} < H_VIS_END) &&
                        ({1'b0, v_next} >= V_VIS_BEG) && ({1'b0, v_next} < V_VIS_END);
      vga.pixelTick  <= pix_en;
      vga.frameStart <= pix_en && (h_next == '0) && (v_next == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole frames fit
// in a short run; the divider ratio follows VGA_PIXEL_DIV_EN.
module tb_vga_timing_gen;

  localparam int HS = 6,  HBP = 5, HA = 16, HFP = 4;
  localparam int VS = 2,  VBP = 3, VA = 8,  VFP = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
`ifdef VGA_PIXEL_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif
  localparam int FRAME_CLKS = HT * VT * DIV;
  localparam int PU_LEN = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .PIX_DIV  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_div   = 0;
  int m_h     = 0;
  int m_v     = 0;
  int last_fs = -1;
  int fs_cnt  = 0;
  logic [24:0] expq[$];
  logic [24:0] pu[PU_LEN];

  function automatic logic [24:0] observed();
    return {vif.hSync, vif.vSync, vif.bright, vif.pixelTick, vif.frameStart,
            vif.hCount, vif.vCount};
  endfunction

  task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_h = 0; m_v = 0; cyc = 0; last_fs = -1;
    expq.delete();
  endtask

  // One clk: advance the reference raster, queue its outputs, compare at negedge.
  task automatic step(input string tag);
    logic pe;
    logic [24:0] obs;
    @(posedge clk);
    cyc++;
    pe = (m_div == DIV - 1);
    if (pe) begin
      m_div = 0;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end else begin
      m_div++;
    end
    expq.push_back({logic'(m_h >= HS), logic'(m_v >= VS),
                    logic'(m_h >= HS + HBP && m_h < HS + HBP + HA &&
                           m_v >= VS + VBP && m_v < VS + VBP + VA),
                    pe, logic'(pe && m_h == 0 && m_v == 0),
                    10'(m_h), 10'(m_v)});
    @(negedge clk);
    obs = observed();
    check(tag, obs, expq.pop_front());
    if (obs[20]) begin
      if (last_fs >= 0)
        check("frame_period", 25'(cyc - last_fs), 25'(FRAME_CLKS));
      last_fs = cyc;
      fs_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_state", observed(), '0);
    end
    model_reset();
    reset = 1'b0;

    for (int i = 0; i < PU_LEN; i++) begin
      step("powerup");
      pu[i] = observed();
    end
    for (int i = 0; i < 3 * FRAME_CLKS; i++) step("raster");
    check("frame_count", 25'(fs_cnt), 25'd3);

    // Run to a mid-line position, then assert reset away from any clk edge.
    for (int i = 0; i < FRAME_CLKS && !(m_h == 20 && m_v == 6 && m_div == 0); i++)
      step("seek");
    check("seek_reached", {15'd0, 10'(m_h)} | {5'd0, 10'(m_v), 10'd0},
          {15'd0, 10'd20} | {5'd0, 10'd6, 10'd0});
    #2 reset = 1'b1;
    #1 check("async_reset", observed(), '0);
    model_reset();
    @(negedge clk);
    check("reset_hold", observed(), '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < PU_LEN; i++) begin
      step("restart");
      check("restart_vs_powerup", observed(), pu[i]);
    end
    for (int i = 0; i < 2 * HT * DIV; i++) step("restart_raster");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA timing: horizontal/vertical pixel counters, active-low sync pulses and the visible-area `bright` qualifier. It is the source of the `hCount`/`vCount`/`bright` interface consumed by the pixel-colour generators. It also drives `hSync`/`vSync` to the board connector. An internal pixel-clock-enable divider runs it from the 100 MHz board clock.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIX_DIV`, 4, clk cycles per pixel (2..16)
- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  asynchronous, active-high reset
- `hSync`  out  1  horizontal sync, active low
- `vSync`  out  1  vertical sync, active low
- `bright`  out  1  high while (hCount, vCount) is in the visible area
- `hCount`  out  10  pixel position in line, 0..H_TOTAL-1
- `vCount`  out  10  line position in frame, 0..V_TOTAL-1
- `pixelTick`  out  1  one-clk pulse, first clk of each new pixel
- `frameStart`  out  1  one-clk pulse, first clk of pixel (0,0)

## Operation
- Derived: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (525). Both must be ≤ 1024. Out-of-range parameters are an elaboration error.
- Line order is sync, back porch, active, front porch. Count 0 is the first sync pixel/line.
- Divider `divCnt` counts 0..PIX_DIV-1. Internal `pixEn` = (divCnt == PIX_DIV-1).
- On a clk edge with pixEn: divCnt←0. Then hCount←hCount+1, or hCount←0 at H_TOTAL-1.
- On the hCount wrap: vCount←vCount+1, or vCount←0 at V_TOTAL-1.
- Outputs are decoded from the next counter values and registered, so all outputs are aligned to the same clk.
  - hSync = 0 iff hCount < H_SYNC (0..95).
  - vSync = 0 iff vCount < V_SYNC (0..1).
  - bright = 1 iff H_SYNC+H_BP ≤ hCount < H_SYNC+H_BP+H_ACTIVE (144..783) and V_SYNC+V_BP ≤ vCount < V_SYNC+V_BP+V_ACTIVE (35..514).
- pixelTick = registered pixEn.
- frameStart = registered (pixEn and the next counters are (0,0)). It never pulses on reset release.

## Timing
- Reset values (asynchronous, immediate): divCnt=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0, pixelTick=0, frameStart=0.
- After reset deasserts, the first counter advance (hCount 0→1) happens on the PIX_DIV-th rising edge. pixelTick is high for the one clk following that edge.
- Each pixel is exactly PIX_DIV clks, each line H_TOTAL pixels, each frame V_TOTAL lines.
- At default parameters a frame is 420,000 pixels = 1,680,000 clks.
- hSync, vSync and bright change on the same edge as hCount/vCount, with zero skew.
- Reset asserted mid-frame forces all outputs to their reset values. Timing restarts from (0,0) as after power-up. No partial-line recovery.

## Configuration
- `VGA_PIXEL_DIV_EN` defined: the divider is present and counters advance once per PIX_DIV clks.
- `VGA_PIXEL_DIV_EN` undefined: the divider is removed and pixEn is tied to 1.
  - Counters advance every clk, pixelTick is 1 from the first clk after reset deasserts, and PIX_DIV is ignored.
  - This mode is for a clk that is already the 25 MHz pixel clock.

## Structure
- `vga_timing_pkg` holds the default timing constants, derived H_TOTAL/V_TOTAL and region-boundary constants. It is shared with pixel generators so they use the same visible-area numbers.
- Sub-module `vga_pixel_div` contains the divider counter and pixEn. It is instantiated only under `VGA_PIXEL_DIV_EN`.
- Counters and output decode stay in `vga_timing_gen`.

## Test plan
- Reset release: hCount=0 for 4 clks, then 1. pixelTick pulses once per 4 clks. hSync=0, vSync=0, bright=0 during line 0.
- Horizontal line: hSync low for hCount 0..95, high for 96..799. On vCount=35, bright is high exactly for hCount 144..783.
- Wrap: hCount 799→0 increments vCount. (799,524)→(0,0) pulses frameStart once. The frameStart period is 1,680,000 clks.
- Vertical: vSync low for vCount 0..1 only. bright is never high on vCount 0..34 or 515..524.
- Mid-line reset at (300,100): all outputs go to reset values without waiting for a clk edge. After release the sequence is identical to power-up.
- `VGA_PIXEL_DIV_EN` undefined: hCount increments every clk, pixelTick stays 1, and the frame is 420,000 clks.
